seq_counter: RTL
================

# seq_counter

Parametrised repeating-sequence counter: steps through a programmable table of WIDTH-bit codes, emitting one code per advance and wrapping after a programmable last entry. Generalises the team's fixed 3-bit T-flip-flop sequence generators. Adds a runtime-writable sequence, a runtime length, forward/reverse direction, synchronous clear, enable gating and a wrap strobe. Sits wherever a non-binary cyclic code is needed: stepper phases, LED patterns, test-pattern sources.

## Interface
- WIDTH, 3, bits per sequence code
- DEPTH, 5, table entries (≥2); AW = max(1, clog2(DEPTH))
- INIT, {3'd3,3'd2,3'd7,3'd4,3'd0}, packed DEPTH×WIDTH reset contents; entry 0 in LSBs, so the reset sequence is 0→4→7→2→3

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- en  in  1  advance one entry this cycle
- dir  in  1  0 = forward (idx+1), 1 = reverse (idx−1)
- clr  in  1  synchronous return to idx 0
- wr_en  in  1  write table entry
- wr_addr  in  AW  entry to write; addresses ≥ DEPTH ignored
- wr_data  in  WIDTH  code to write
- len_we  in  1  load last-index register
- len_data  in  AW  new last index; values > DEPTH−1 saturate to DEPTH−1
- q  out  WIDTH  current code = table[idx]
- idx  out  AW  current table index
- last  out  AW  current last index
- wrap  out  1  one-cycle strobe: sequence wrapped on previous edge

## Operation
- Reset (reset=0): table←INIT, idx←0, last←DEPTH−1, wrap←0, so q=INIT[0]. Reset is asynchronous in assertion and release; no partial update survives reset asserted mid-operation.
- Per-edge idx update, in priority order:
  1. clr=1: idx←0, wrap←0.
  2. len_we=1 and idx > new last: idx←0, wrap←0. This overrides en.
  3. en=1, dir=0: if idx==last, idx←0 and wrap←1; else idx←idx+1.
  4. en=1, dir=1: if idx==0, idx←last and wrap←1; else idx←idx−1.
  5. Otherwise: idx holds, wrap←0.
- The comparison in step 3 uses the last value before this edge's len_we. A len_we on the same edge affects only the following steps.
- last=0 is legal. Every enabled advance then holds idx=0 and pulses wrap each cycle.
- Table write: table[wr_addr]←wr_data on the edge. It is independent of idx update and legal in any cycle, including a write to the current or next entry.
- q is a combinational read of registered table and idx; it has no other logic.
- dir may change on any cycle with no penalty.

## Timing
- Advance latency: en sampled at edge N; idx and q show the new entry after edge N.
- wrap is registered. It is high for exactly the cycle following the wrapping edge and is never asserted two cycles in a row unless last=0 or a wrap recurs.
- Write visibility: a write to entry k at edge N is seen on q after edge N if idx==k after edge N. This includes an advance into k on that same edge: the new data appears, not the old.
- len_we takes effect at its edge; the next wrap decision uses the new last.
- Throughput: one advance per cycle, sustained indefinitely.

## Structure
- Package seq_counter_pkg holds:
  - an addr-width function (max(1, clog2));
  - the default INIT constant;
  - a saturate-length helper.
- Sub-module seq_table: DEPTH×WIDTH register file with async active-low reset to INIT, one write port and one combinational read port. seq_counter instantiates it plus the idx/last/wrap control.

## Test plan
- Reset then en=1, dir=0 for 7 cycles → q = 0,4,7,2,3,0,4. wrap is high only in the cycle q first returns to 0; idx = 0,1,2,3,4,0,1.
- dir=1 from idx 0 with defaults → q = 3,2,7,4,0,3. wrap is high in the cycle after 0→4.
- len_we with len_data=2 while idx=4, en=1 → idx=0, q=0, no wrap. Then advances give 0,4,7,0 with wrap on the return.
- len_data=7 with DEPTH=5 → last reads 4.
- wr_en to addr 1 with data 5, simultaneous with an advance from idx 0 → q=5 the next cycle. wr_addr=6 → no table change.
- clr and en together at idx 3 → idx=0, wrap=0.
- Assert reset mid-sequence, asynchronously between edges → q=0, idx=0 and last=4 immediately, and table contents are restored to INIT.

Source files
------------

// File: rtl/seq_counter_pkg.sv
// Shared constants and helpers for the repeating-sequence counter.
// Latency: n/a (compile-time functions and constants only).
// Backpressure: n/a.
package seq_counter_pkg;

  localparam int SEQ_DEFAULT_WIDTH = 3;
  localparam int SEQ_DEFAULT_DEPTH = 5;

  // Entry 0 sits in the LSBs, so the power-on sequence is 0,4,7,2,3.
  localparam logic [SEQ_DEFAULT_DEPTH*SEQ_DEFAULT_WIDTH-1:0] SEQ_DEFAULT_INIT =
    {3'd3, 3'd2, 3'd7, 3'd4, 3'd0};

  // Index width: never narrower than one bit, even for a two-entry table.
  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Clamp a requested last index to the top of the table.
  function automatic int sat_last(input int len, input int depth);
    return (len > depth - 1) ? depth - 1 : len;
  endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH code table: one write port, one combinational read port.
// Latency: write lands on the clock edge; read is combinational from the registers.
// Backpressure: none; a write is accepted every cycle, out-of-range addresses are dropped.
module seq_table
  import seq_counter_pkg::*;
#(
  parameter int                     WIDTH = SEQ_DEFAULT_WIDTH,
  parameter int                     DEPTH = SEQ_DEFAULT_DEPTH,
  parameter logic [DEPTH*WIDTH-1:0] INIT  = SEQ_DEFAULT_INIT,
  localparam int                    AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // One spare bit so a power-of-two DEPTH still fits in the bound.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);

  // Table storage: reload INIT on reset, otherwise take in-range writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= INIT;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The index is always kept below DEPTH by the controller.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/seq_counter.sv
// Repeating-sequence counter: walks a programmable code table forward or reverse and wraps at a runtime last index.
// Latency: en sampled at edge N moves idx/q after edge N; wrap is a registered strobe for the following cycle.
// Backpressure: none; en simply gates advancing, one advance per cycle can be sustained.
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter int                     WIDTH = SEQ_DEFAULT_WIDTH,
  parameter int                     DEPTH = SEQ_DEFAULT_DEPTH,
  parameter logic [DEPTH*WIDTH-1:0] INIT  = SEQ_DEFAULT_INIT,
  localparam int                    AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             len_we,
  input  logic [AW-1:0]    len_data,
  output logic [WIDTH-1:0] q,
  output logic [AW-1:0]    idx,
  output logic [AW-1:0]    last,
  output logic             wrap
);

  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  logic [AW-1:0] idx_r, idx_nxt;
  logic [AW-1:0] last_r, last_nxt;
  logic [AW-1:0] len_sat;
  logic          wrap_r, wrap_nxt;

  assign len_sat = AW'(sat_last(int'(len_data), DEPTH));

  // Next index / last / wrap. Wrap decisions (and the reverse wrap target)
  // use last as it stood before this edge; a same-edge len_we only counts
  // for the "index now beyond the end" check, which snaps back to 0.
  always_comb begin
    idx_nxt  = idx_r;
    wrap_nxt = 1'b0;
    last_nxt = len_we ? len_sat : last_r;
    if (clr) begin
      idx_nxt = '0;
    end else if (len_we && (idx_r > len_sat)) begin
      idx_nxt = '0;
    end else if (en && !dir) begin
      if (idx_r == last_r) begin
        idx_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        idx_nxt = idx_r + AW'(1);
      end
    end else if (en && dir) begin
      if (idx_r == '0) begin
        idx_nxt  = last_r;
        wrap_nxt = 1'b1;
      end else begin
        idx_nxt = idx_r - AW'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r  <= '0;
      last_r <= LAST_MAX;
      wrap_r <= 1'b0;
    end else begin
      idx_r  <= idx_nxt;
      last_r <= last_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  // Reads after a same-edge write return the new data because q is a
  // plain combinational read of the updated registers.
  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (INIT)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_r),
    .rd_data (q)
  );

  assign idx  = idx_r;
  assign last = last_r;
  assign wrap = wrap_r;

endmodule
